// File: rtl/keypad_pkg.sv
// Shared types and key-code helpers for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } scan_state_e;

    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    // Code for the key at (row, col); A..D are 10..13.
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0:    code = 4'd1;
            4'h1:    code = 4'd2;
            4'h2:    code = 4'd3;
            4'h3:    code = 4'd10;
            4'h4:    code = 4'd4;
            4'h5:    code = 4'd5;
            4'h6:    code = 4'd6;
            4'h7:    code = 4'd11;
            4'h8:    code = 4'd7;
            4'h9:    code = 4'd8;
            4'hA:    code = 4'd9;
            4'hB:    code = 4'd12;
            4'hC:    code = KEY_STAR;
            4'hD:    code = 4'd0;
            4'hE:    code = KEY_HASH;
            4'hF:    code = 4'd13;
            default: code = 4'd0;
        endcase
        return code;
    endfunction

    // True when exactly one active-low row is asserted.
    function automatic logic single_low(input logic [3:0] rows);
        logic hit;
        case (rows)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: hit = 1'b1;
            default:                            hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Index of the low row; only meaningful when single_low() holds.
    function automatic logic [1:0] low_row(input logic [3:0] rows);
        logic [1:0] idx;
        case (rows)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Metastability-settling chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row debounce, key encode, one pulse per press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    logic [3:0]    row_s;
    logic          press_s;
    logic [3:0]    code_s;
    logic          tick_s;

    logic [DW-1:0] div_r;
    scan_state_e   state_r,  state_nxt;
    logic [1:0]    col_idx_r, col_idx_nxt;
    logic [3:0]    col_n_r;
    logic [3:0]    cand_r,   cand_nxt;
    logic [CW-1:0] stable_r, stable_nxt;
    logic [CW-1:0] rel_r,    rel_nxt;
    logic [3:0]    digit_r,  digit_nxt;
    logic          valid_r,  valid_nxt;
    logic          held_r,   held_nxt;

    sync_2ff #(
        .WIDTH     (4),
        .RESET_VAL (4'hF)
    ) u_row_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (row_n),
        .q       (row_s)
    );

    assign tick_s  = (div_r == DIV_MAX);
    assign press_s = single_low(row_s);
    assign code_s  = key_code(low_row(row_s), col_idx_r);

    // Next-state and datapath decisions, evaluated only on dwell ticks.
    always_comb begin
        state_nxt   = state_r;
        col_idx_nxt = col_idx_r;
        cand_nxt    = cand_r;
        stable_nxt  = stable_r;
        rel_nxt     = rel_r;
        digit_nxt   = digit_r;
        valid_nxt   = 1'b0;
        held_nxt    = held_r;
        if (tick_s) begin
            case (state_r)
                SCAN: begin
                    if (press_s) begin
                        cand_nxt   = code_s;
                        stable_nxt = CNT_ONE;
                        if (DEBOUNCE_CNT == 1) begin
                            digit_nxt = code_s;
                            valid_nxt = 1'b1;
                            held_nxt  = 1'b1;
                            state_nxt = HELD;
                        end else begin
                            state_nxt = DEBOUNCE;
                        end
                    end else begin
                        col_idx_nxt = col_idx_r + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (press_s && (code_s == cand_r)) begin
                        stable_nxt = sat_inc(stable_r);
                        if (stable_nxt == CNT_MAX) begin
                            digit_nxt = cand_r;
                            valid_nxt = 1'b1;
                            held_nxt  = 1'b1;
                            state_nxt = HELD;
                        end else begin
                            state_nxt = DEBOUNCE;
                        end
                    end else begin
                        stable_nxt  = '0;
                        state_nxt   = SCAN;
                        col_idx_nxt = col_idx_r + 2'd1;
                    end
                end
                HELD: begin
                    // Any low row keeps the hold; a second key cannot start a new press here.
                    if (row_s == 4'hF) begin
                        rel_nxt = CNT_ONE;
                        if (DEBOUNCE_CNT == 1) begin
                            rel_nxt     = '0;
                            held_nxt    = 1'b0;
                            state_nxt   = SCAN;
                            col_idx_nxt = col_idx_r + 2'd1;
                        end else begin
                            state_nxt = RELEASE;
                        end
                    end else begin
                        state_nxt = HELD;
                    end
                end
                RELEASE: begin
                    if (row_s == 4'hF) begin
                        rel_nxt = sat_inc(rel_r);
                        if (rel_nxt == CNT_MAX) begin
                            rel_nxt     = '0;
                            held_nxt    = 1'b0;
                            state_nxt   = SCAN;
                            col_idx_nxt = col_idx_r + 2'd1;
                        end else begin
                            state_nxt = RELEASE;
                        end
                    end else begin
                        rel_nxt   = '0;
                        state_nxt = HELD;
                    end
                end
                default: begin
                    state_nxt = SCAN;
                end
            endcase
        end else begin
            state_nxt = state_r;
        end
    end

    // State, divider, column drive and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_r     <= '0;
            state_r   <= SCAN;
            col_idx_r <= 2'd0;
            col_n_r   <= 4'b1110;
            cand_r    <= 4'd0;
            stable_r  <= '0;
            rel_r     <= '0;
            digit_r   <= 4'd0;
            valid_r   <= 1'b0;
            held_r    <= 1'b0;
        end else begin
            div_r     <= tick_s ? '0 : div_r + DW'(1);
            state_r   <= state_nxt;
            col_idx_r <= col_idx_nxt;
            col_n_r   <= ~(4'b0001 << col_idx_nxt);
            cand_r    <= cand_nxt;
            stable_r  <= stable_nxt;
            rel_r     <= rel_nxt;
            digit_r   <= digit_nxt;
            valid_r   <= valid_nxt;
            held_r    <= held_nxt;
        end
    end

    assign col_n       = col_n_r;
    assign digit       = digit_r;
    assign digit_valid = valid_r;
    assign key_held    = held_r;

endmodule
